led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl_pkg.sv | 64 ++++++
 rtl/key_debounce.sv | 60 ++++++
 rtl/led_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl_pkg
// Shared definitions for the LED sequencer: mode and control-FSM encodings,
// the initial LED / RGB patterns of each mode, the minimum legal tick period
// and small pattern helpers used by the top level.
// -----------------------------------------------------------------------------
package led_seq_ctrl_pkg;

  // Pattern modes as seen on cfg_mode / mode.
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ROT   = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  // Control FSM: RUN accepts requests, APPLY commits the pending ones.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  localparam int          PERIOD_W   = 25;
  localparam logic [PERIOD_W-1:0] PERIOD_MIN = 25'd2;

  // Initial single-colour patterns.
  localparam logic [7:0]  LED_INIT_ROT   = 8'h01;
  localparam logic [7:0]  LED_INIT_PING  = 8'h01;
  localparam logic [7:0]  LED_INIT_BLINK = 8'h00;
  localparam logic [7:0]  LED_DARK       = 8'h00;

  // Initial RGB pattern, ld4..ld1 from left to right.
  localparam logic [11:0] RGB_INIT = 12'b101_101_110_011;
  localparam logic [11:0] RGB_DARK = 12'h000;

  // A period below 2 would make the counter wrap every cycle or never tick.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_MIN) ? PERIOD_MIN : p;
  endfunction

  function automatic logic [7:0] led_init(input mode_e m);
    case (m)
      MODE_ROT:   return LED_INIT_ROT;
      MODE_PING:  return LED_INIT_PING;
      MODE_BLINK: return LED_INIT_BLINK;
      default:    return LED_DARK;
    endcase
  endfunction

  function automatic logic [11:0] rgb_init(input mode_e m);
    return (m == MODE_OFF) ? RGB_DARK : RGB_INIT;
  endfunction

  // Rotate each 3-bit colour group right by one, independently.
  function automatic logic [11:0] rgb_rotate(input logic [11:0] rgb);
    logic [11:0] r;
    r = '0;
    for (int g = 0; g < 4; g++) begin
      r[g*3 +: 3] = {rgb[g*3], rgb[g*3+2 -: 2]};
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises the raw, active-low push-button into the clk domain and
// debounces it. The debounced level follows the synchronised input only after
// the two have disagreed for DB_CYCLES consecutive cycles; any agreement
// restarts the count. A one-cycle key_press marks each debounced 1->0 change.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   key_n     raw button, low = pressed, asynchronous to clk
//   key_press one-cycle pulse on a debounced press
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter logic [19:0] DB_CYCLES = 20'd240000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_press
);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic [19:0] cnt;
  logic        mismatch;
  logic        settle;

  assign mismatch = (sync2 != level);
  // This cycle is the DB_CYCLES-th consecutive disagreement: level flips now.
  assign settle   = mismatch && (cnt == DB_CYCLES - 20'd1);

  // The pulse is decoded from registered state, so it lasts exactly the one
  // cycle in which the level is about to fall.
  assign key_press = settle && !sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
// LED pattern sequencer. A free-running period counter produces a one-cycle
// tick every period_reg cycles; on each tick in RUN the current mode's LED and
// RGB patterns advance. Mode/period changes come from a host valid/ready
// handshake or from a debounced push-button (next mode, same period) and are
// committed through a one-cycle APPLY state, which also restarts the counter
// and reloads the patterns.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   key_n            raw push-button, low = pressed
//   cfg_valid/ready  configuration handshake
//   cfg_mode         requested mode (OFF, ROT, PING, BLINK)
//   cfg_period       requested tick period in cycles (clamped to >= 2)
//   mode             current mode
//   tick             one-cycle pulse at each pattern step
//   led              single-colour pattern
//   ld1..ld4         RGB LEDs, ld1 = rgb[2:0] ... ld4 = rgb[11:9]
// -----------------------------------------------------------------------------
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter logic [24:0] DEFAULT_PERIOD = 25'd600,
  parameter logic [19:0] DB_CYCLES      = 20'd240000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_mode,
  input  logic [24:0] cfg_period,
  output logic [1:0]  mode,
  output logic        tick,
  output logic [7:0]  led,
  output logic [2:0]  ld1,
  output logic [2:0]  ld2,
  output logic [2:0]  ld3,
  output logic [2:0]  ld4
);

  state_e              state;
  state_e              state_nxt;
  mode_e               mode_r;
  mode_e               pend_mode;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] pend_period;
  logic [PERIOD_W-1:0] cnt;
  logic [7:0]          led_r;
  logic [11:0]         rgb_r;
  logic                dir_left;

  logic                key_press;
  logic                cfg_fire;
  logic                key_fire;
  logic                apply_now;
  logic                ping_left;
  logic [7:0]          ping_led;

  // ---------------------------------------------------------------------------
  // Push-button front end
  // ---------------------------------------------------------------------------
  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_key_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .key_press (key_press)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    cfg_fire  = 1'b0;
    key_fire  = 1'b0;
    apply_now = 1'b0;
    case (state)
      ST_RUN: begin
        cfg_ready = 1'b1;
        // The host request wins; a simultaneous key press is simply lost.
        if (cfg_valid) begin
          cfg_fire  = 1'b1;
          state_nxt = ST_APPLY;
        end else if (key_press) begin
          key_fire  = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // Presses seen here are dropped: nothing latches them.
        apply_now = 1'b1;
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending configuration
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mode   <= MODE_ROT;
      pend_period <= DEFAULT_PERIOD;
    end else if (cfg_fire) begin
      pend_mode   <= mode_e'(cfg_mode);
      pend_period <= clamp_period(cfg_period);
    end else if (key_fire) begin
      pend_mode   <= mode_e'(mode_r + 2'd1);
      pend_period <= period_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter and tick
  // ---------------------------------------------------------------------------
  assign tick = (cnt == period_reg - 25'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (apply_now || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 25'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern generation
  // ---------------------------------------------------------------------------
  // PING turns around at either end before shifting, so the end LEDs are
  // shown for one step only.
  always_comb begin
    ping_left = dir_left;
    if (led_r == 8'h80) begin
      ping_left = 1'b0;
    end else if (led_r == 8'h01) begin
      ping_left = 1'b1;
    end
    ping_led = ping_left ? {led_r[6:0], 1'b0} : {1'b0, led_r[7:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= MODE_ROT;
      period_reg <= DEFAULT_PERIOD;
      led_r      <= LED_INIT_ROT;
      rgb_r      <= RGB_INIT;
      dir_left   <= 1'b1;
    end else if (apply_now) begin
      // Commit even when the mode is unchanged so the pattern restarts.
      mode_r     <= pend_mode;
      period_reg <= pend_period;
      led_r      <= led_init(pend_mode);
      rgb_r      <= rgb_init(pend_mode);
      dir_left   <= 1'b1;
    end else if (state == ST_RUN && tick) begin
      case (mode_r)
        MODE_ROT: begin
          led_r <= {led_r[0], led_r[7:1]};
          rgb_r <= rgb_rotate(rgb_r);
        end
        MODE_PING: begin
          led_r    <= ping_led;
          dir_left <= ping_left;
          rgb_r    <= rgb_rotate(rgb_r);
        end
        MODE_BLINK: begin
          led_r <= ~led_r;
          rgb_r <= rgb_rotate(rgb_r);
        end
        default: begin
          led_r <= LED_DARK;
          rgb_r <= RGB_DARK;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mode = mode_r;
  assign led  = led_r;
  assign ld1  = rgb_r[2:0];
  assign ld2  = rgb_r[5:3];
  assign ld3  = rgb_r[8:6];
  assign ld4  = rgb_r[11:9];

endmodule

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl
// Self-checking bench for led_seq_ctrl with DB_CYCLES = 4, DEFAULT_PERIOD = 4.
// The reference model tracks, per committed configuration, the number of
// cycles since the commit and the number of ticks taken; expected patterns
// are computed arithmetically from those counts.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;

  localparam int DBC  = 4;
  localparam int DEFP = 4;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        key_n      = 1'b1;
  logic        cfg_valid  = 1'b0;
  logic [1:0]  cfg_mode   = 2'd0;
  logic [24:0] cfg_period = 25'd0;
  logic        cfg_ready;
  logic [1:0]  mode;
  logic        tick;
  logic [7:0]  led;
  logic [2:0]  ld1, ld2, ld3, ld4;

  led_seq_ctrl #(
    .DEFAULT_PERIOD (25'(DEFP)),
    .DB_CYCLES      (20'(DBC))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .mode       (mode),
    .tick       (tick),
    .led        (led),
    .ld1        (ld1),
    .ld2        (ld2),
    .ld3        (ld3),
    .ld4        (ld4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_mode, m_period;     // committed configuration
  int m_c;                  // cycles since commit (or reset)
  int m_k;                  // ticks taken since commit (or reset)
  bit m_apply;              // a request is pending commit
  int m_pmode, m_pperiod;
  bit m_k1, m_k2;           // key samples one and two edges ago
  bit m_level;              // debounced key level
  int m_run;                // consecutive cycles synced key != level

  task automatic model_reset();
    m_mode = 1; m_period = DEFP; m_c = 0; m_k = 0; m_apply = 0;
    m_pmode = 1; m_pperiod = DEFP;
    m_k1 = 1; m_k2 = 1; m_level = 1; m_run = 0;
  endtask

  // True when the coming edge carries a debounced press.
  function automatic bit press_next();
    return (m_k2 != m_level) && (m_run + 1 == DBC) && (m_k2 == 1'b0);
  endfunction

  function automatic logic [7:0] exp_led(input int md, input int k);
    int pos;
    logic [7:0] one;
    one = 8'h01;
    case (md)
      1: return one << ((8 - (k % 8)) % 8);
      2: begin
        pos = k % 14;
        return one << ((pos <= 7) ? pos : 14 - pos);
      end
      3: return (k % 2 == 1) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] exp_grp(input int g, input int md, input int k);
    logic [2:0] v;
    if (md == 0) return 3'b000;
    case (g)
      0:       v = 3'b011;
      1:       v = 3'b110;
      default: v = 3'b101;
    endcase
    for (int i = 0; i < k % 3; i++) v = {v[0], v[2:1]};
    return v;
  endfunction

  // Advance the model across one rising edge using the inputs held at it.
  task automatic model_step();
    bit press;
    bit tick_now;
    press = 0;
    if (m_k2 != m_level) begin
      m_run++;
      if (m_run == DBC) begin
        m_level = m_k2;
        m_run   = 0;
        press   = (m_level == 0);
      end
    end else begin
      m_run = 0;
    end
    m_k2 = m_k1;
    m_k1 = key_n;

    tick_now = ((m_c % m_period) == m_period - 1);
    if (!m_apply) begin
      if (tick_now) m_k++;
      if (cfg_valid) begin
        m_pmode   = int'(cfg_mode);
        m_pperiod = (cfg_period < 25'd2) ? 2 : int'(cfg_period);
        m_apply   = 1;
      end else if (press) begin
        m_pmode   = (m_mode + 1) % 4;
        m_pperiod = m_period;
        m_apply   = 1;
      end
      m_c++;
    end else begin
      m_mode   = m_pmode;
      m_period = m_pperiod;
      m_c      = 0;
      m_k      = 0;
      m_apply  = 0;
    end
  endtask

  task automatic compare_all();
    check("mode",      32'(mode),      32'(m_mode));
    check("tick",      32'(tick),      32'((m_c % m_period) == m_period - 1));
    check("led",       32'(led),       32'(exp_led(m_mode, m_k)));
    check("ld1",       32'(ld1),       32'(exp_grp(0, m_mode, m_k)));
    check("ld2",       32'(ld2),       32'(exp_grp(1, m_mode, m_k)));
    check("ld3",       32'(ld3),       32'(exp_grp(2, m_mode, m_k)));
    check("ld4",       32'(ld4),       32'(exp_grp(3, m_mode, m_k)));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_apply));
  endtask

  // Inputs change on the falling edge; outputs are compared there too.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic do_cfg(input logic [1:0] md, input logic [24:0] p);
    cfg_valid  = 1'b1;
    cfg_mode   = md;
    cfg_period = p;
    cycle(1);
    cfg_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int hold;

    model_reset();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Free run in the reset mode.
    cycle(12);

    // Short glitch ignored, long press gives exactly one ROT->PING step.
    key_n = 1'b0; cycle(2);
    key_n = 1'b1; cycle(10);
    key_n = 1'b0; cycle(10);
    key_n = 1'b1; cycle(12);
    check("key_to_ping", 32'(mode), 32'd2);

    // PING with period 3 through both turnarounds, then clamped period 0.
    do_cfg(2'd2, 25'd3);
    cycle(50);
    do_cfg(2'd2, 25'd0);
    cycle(12);
    // Re-apply the same mode: pattern and counter restart.
    do_cfg(2'd2, 25'd1);
    cycle(9);

    // Host request on the same edge as a debounced press: host wins.
    seen  = 0;
    key_n = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (press_next()) begin
        seen       = 1;
        cfg_valid  = 1'b1;
        cfg_mode   = 2'd3;
        cfg_period = 25'd4;
      end
      cycle(1);
      cfg_valid = 1'b0;
    end
    if (!seen) check("coincide_found", 32'd0, 32'd1);
    cycle(2);
    check("cfg_wins", 32'(mode), 32'd3);
    key_n = 1'b1;
    cycle(10);

    // OFF keeps ticking with dark LEDs.
    do_cfg(2'd0, 25'd4);
    cycle(12);

    // Reset while a request is being applied: it is discarded.
    do_cfg(2'd2, 25'd3);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    cycle(1);
    rst_n = 1'b1;
    cycle(12);
    check("reset_discard", 32'(mode), 32'd1);

    // Randomised host requests and key activity.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        key_n = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) begin
        cfg_valid  = 1'b1;
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_period = 25'($urandom_range(0, 6));
      end
      cycle(1);
      cfg_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
